// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between the in-order pipeline
// writeback and a secondary long-latency requester (e.g. mul/div returning to
// a GPR). The pipeline has priority; a one-entry hold buffer parks a secondary
// result until a free write slot appears. All rf_* outputs are registered, so a
// winning request reaches the register file one rising edge later.
//
// Optional feature macro: WB_STARVE_GUARD_EN
//   defined   - a wait counter forces a drain (pipe_stall for one cycle) once a
//               buffered result has waited MAX_WAIT pipeline writes.
//   undefined - no counter, pipe_stall tied low; the buffer drains only on a
//               cycle without a live pipeline write or via a same-address squash.
//
// Parameters
//   MAX_WAIT   cycles a buffered result may wait before the guard forces a slot
//   CNT_W      wait counter width, 2**CNT_W > MAX_WAIT
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   p_wen       in   pipeline writeback request
//   p_waddr     in   pipeline destination GPR (5b)
//   p_wdata     in   pipeline writeback data (32b)
//   s_valid     in   secondary result valid
//   s_waddr     in   secondary destination GPR (5b)
//   s_wdata     in   secondary result data (32b)
//   s_ready     out  secondary result accepted when s_valid && s_ready
//   rf_wen      out  register-file write enable (registered)
//   rf_waddr    out  register-file write address (registered)
//   rf_wdata    out  register-file write data (registered)
//   pipe_stall  out  hold the WB stage; pipeline re-presents its write next cycle
//   busy        out  hold buffer occupied
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        p_wen,
  input  logic [4:0]  p_waddr,
  input  logic [31:0] p_wdata,
  input  logic        s_valid,
  input  logic [4:0]  s_waddr,
  input  logic [31:0] s_wdata,
  output logic        s_ready,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pipe_stall,
  output logic        busy
);

  // The counter must be able to hold MAX_WAIT itself.
  if ((2 ** CNT_W) <= MAX_WAIT) begin : g_bad_cfg
    $error("wb_port_arbiter: CNT_W too small for MAX_WAIT");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e      state_q,    state_d;
  logic [4:0]  buf_addr_q, buf_addr_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic        rf_wen_q,   rf_wen_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        p_live_s;
  logic        s_live_s;
  logic        stall_s;

  // A write to $0 is never live: it must not reach the register file.
  assign p_live_s = p_wen   && (p_waddr != 5'd0);
  assign s_live_s = s_valid && (s_waddr != 5'd0);

`ifdef WB_STARVE_GUARD_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign stall_s = (state_q == FULL) && (cnt_q == CNT_W'(MAX_WAIT));

  // Wait counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign stall_s = 1'b0;
`endif

  assign s_ready    = (state_q == EMPTY);
  assign busy       = (state_q == FULL);
  assign pipe_stall = stall_s;

  // Next-state and write-port selection.
  always_comb begin
    state_d    = state_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
`ifdef WB_STARVE_GUARD_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      EMPTY: begin
        if (p_live_s) begin
          rf_wen_d   = 1'b1;
          rf_waddr_d = p_waddr;
          rf_wdata_d = p_wdata;
          if (s_live_s) begin
            // Pipeline wins the port; park the secondary result.
            buf_addr_d = s_waddr;
            buf_data_d = s_wdata;
            state_d    = FULL;
`ifdef WB_STARVE_GUARD_EN
            cnt_d      = '0;
`endif
          end else begin
            state_d = EMPTY;
          end
        end else if (s_live_s) begin
          rf_wen_d   = 1'b1;
          rf_waddr_d = s_waddr;
          rf_wdata_d = s_wdata;
        end else begin
          // Idle, or a $0 secondary write accepted and dropped.
          rf_wen_d = 1'b0;
        end
      end
      FULL: begin
        if (stall_s || !p_live_s) begin
          // Forced or free slot: drain the buffer; p (if any) is re-presented.
          rf_wen_d   = 1'b1;
          rf_waddr_d = buf_addr_q;
          rf_wdata_d = buf_data_q;
          state_d    = EMPTY;
        end else if (p_waddr == buf_addr_q) begin
          // The younger pipeline write supersedes the buffered value.
          rf_wen_d   = 1'b1;
          rf_waddr_d = p_waddr;
          rf_wdata_d = p_wdata;
          state_d    = EMPTY;
        end else begin
          rf_wen_d   = 1'b1;
          rf_waddr_d = p_waddr;
          rf_wdata_d = p_wdata;
`ifdef WB_STARVE_GUARD_EN
          if (cnt_q != CNT_W'(MAX_WAIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
`endif
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State, hold buffer and registered write port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      buf_addr_q <= 5'd0;
      buf_data_q <= 32'd0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic        clock;
  logic        reset;
  logic        p_wen;
  logic [4:0]  p_waddr;
  logic [31:0] p_wdata;
  logic        s_valid;
  logic [4:0]  s_waddr;
  logic [31:0] s_wdata;
  logic        s_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pipe_stall;
  logic        busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  wb_port_arbiter #(.MAX_WAIT(4), .CNT_W(3)) dut (
    .clock(clock), .reset(reset),
    .p_wen(p_wen), .p_waddr(p_waddr), .p_wdata(p_wdata),
    .s_valid(s_valid), .s_waddr(s_waddr), .s_wdata(s_wdata),
    .s_ready(s_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pipe_stall(pipe_stall), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge, return on the following falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive_p(input logic en, input logic [4:0] a, input logic [31:0] d);
    p_wen = en; p_waddr = a; p_wdata = d;
  endtask

  task automatic drive_s(input logic v, input logic [4:0] a, input logic [31:0] d);
    s_valid = v; s_waddr = a; s_wdata = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_p(1'b0, 5'd0, 32'd0);
    drive_s(1'b1, 5'd5, 32'h55);
    step(); step();
    total_cnt++; if (rf_wen !== 1'b0) $display("FAIL reset_rf_wen got %b exp 0", rf_wen); else pass_cnt++;
    total_cnt++; if (rf_waddr !== 5'd0) $display("FAIL reset_rf_waddr got %0d exp 0", rf_waddr); else pass_cnt++;
    total_cnt++; if (rf_wdata !== 32'd0) $display("FAIL reset_rf_wdata got %h exp 0", rf_wdata); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    drive_s(1'b0, 5'd0, 32'd0);
    reset = 1'b0;
    total_cnt++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready got %b exp 1", s_ready); else pass_cnt++;
    step();
    total_cnt++; if (rf_wen !== 1'b0) $display("FAIL post_reset_rf_wen got %b exp 0", rf_wen); else pass_cnt++;
    total_cnt++; if (pipe_stall !== 1'b0) $display("FAIL post_reset_stall got %b exp 0", pipe_stall); else pass_cnt++;
  endtask

  task automatic test_capture_drain();
    drive_p(1'b1, 5'd3, 32'h11);
    drive_s(1'b1, 5'd5, 32'h22);
    total_cnt++; if (s_ready !== 1'b1) $display("FAIL cap_s_ready got %b exp 1", s_ready); else pass_cnt++;
    step();
    drive_s(1'b0, 5'd0, 32'd0);
    drive_p(1'b0, 5'd0, 32'd0);
    total_cnt++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h11})
      $display("FAIL cap_write got wen=%b a=%0d d=%h exp 1/3/11", rf_wen, rf_waddr, rf_wdata); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL cap_busy got %b exp 1", busy); else pass_cnt++;
    total_cnt++; if (s_ready !== 1'b0) $display("FAIL cap_s_ready_full got %b exp 0", s_ready); else pass_cnt++;
    step();
    total_cnt++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h22})
      $display("FAIL drain_write got wen=%b a=%0d d=%h exp 1/5/22", rf_wen, rf_waddr, rf_wdata); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL drain_busy got %b exp 0", busy); else pass_cnt++;
    step();
    total_cnt++; if (rf_wen !== 1'b0) $display("FAIL drain_idle_wen got %b exp 0", rf_wen); else pass_cnt++;
  endtask

  task automatic test_zero_addr();
    drive_s(1'b1, 5'd0, 32'hFF);
    total_cnt++; if (s_ready !== 1'b1) $display("FAIL zero_s_handshake got %b exp 1", s_ready); else pass_cnt++;
    step();
    drive_s(1'b0, 5'd0, 32'd0);
    total_cnt++; if (rf_wen !== 1'b0) $display("FAIL zero_s_wen got %b exp 0", rf_wen); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL zero_s_busy got %b exp 0", busy); else pass_cnt++;
    drive_p(1'b1, 5'd0, 32'h33);
    step();
    drive_p(1'b0, 5'd0, 32'd0);
    total_cnt++; if (rf_wen !== 1'b0) $display("FAIL zero_p_wen got %b exp 0", rf_wen); else pass_cnt++;
  endtask

  task automatic test_squash();
    drive_p(1'b1, 5'd1, 32'h01);
    drive_s(1'b1, 5'd7, 32'hAA);
    step();
    drive_s(1'b0, 5'd0, 32'd0);
    total_cnt++; if (busy !== 1'b1) $display("FAIL squash_busy got %b exp 1", busy); else pass_cnt++;
    drive_p(1'b1, 5'd7, 32'hBB);
    step();
    drive_p(1'b0, 5'd0, 32'd0);
    total_cnt++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'hBB})
      $display("FAIL squash_write got wen=%b a=%0d d=%h exp 1/7/bb", rf_wen, rf_waddr, rf_wdata); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL squash_empty got %b exp 0", busy); else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      step();
      total_cnt++; if (rf_wen !== 1'b0) $display("FAIL squash_no_stale_write got wen=%b a=%0d d=%h exp 0", rf_wen, rf_waddr, rf_wdata); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    drive_s(1'b1, 5'd4, 32'h44);
    step();
    total_cnt++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h44})
      $display("FAIL b2b_s1 got wen=%b a=%0d d=%h exp 1/4/44", rf_wen, rf_waddr, rf_wdata); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_direct_busy got %b exp 0", busy); else pass_cnt++;
    drive_s(1'b1, 5'd6, 32'h66);
    step();
    drive_s(1'b0, 5'd0, 32'd0);
    total_cnt++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd6, 32'h66})
      $display("FAIL b2b_s2 got wen=%b a=%0d d=%h exp 1/6/66", rf_wen, rf_waddr, rf_wdata); else pass_cnt++;
    drive_p(1'b1, 5'd8, 32'h88);
    step();
    drive_p(1'b0, 5'd0, 32'd0);
    total_cnt++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd8, 32'h88})
      $display("FAIL b2b_p got wen=%b a=%0d d=%h exp 1/8/88", rf_wen, rf_waddr, rf_wdata); else pass_cnt++;
    step();
  endtask

  // Buffer (r12,0xCC) held while the pipeline writes r9 every cycle.
  task automatic test_starve();
    drive_p(1'b1, 5'd2, 32'h02);
    drive_s(1'b1, 5'd12, 32'hCC);
    step();
    drive_s(1'b0, 5'd0, 32'd0);
    total_cnt++; if (busy !== 1'b1) $display("FAIL starve_capture_busy got %b exp 1", busy); else pass_cnt++;
`ifdef WB_STARVE_GUARD_EN
    for (int k = 0; k < 4; k++) begin
      drive_p(1'b1, 5'd9, 32'h90 + k);
      total_cnt++; if (pipe_stall !== 1'b0) $display("FAIL guard_early_stall k=%0d got %b exp 0", k, pipe_stall); else pass_cnt++;
      step();
      total_cnt++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h90 + k})
        $display("FAIL guard_p_write k=%0d got wen=%b a=%0d d=%h exp 1/9/%h", k, rf_wen, rf_waddr, rf_wdata, 32'h90 + k); else pass_cnt++;
    end
    drive_p(1'b1, 5'd9, 32'h99);
    total_cnt++; if (pipe_stall !== 1'b1) $display("FAIL guard_stall got %b exp 1", pipe_stall); else pass_cnt++;
    step();
    total_cnt++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd12, 32'hCC})
      $display("FAIL guard_forced_drain got wen=%b a=%0d d=%h exp 1/12/cc", rf_wen, rf_waddr, rf_wdata); else pass_cnt++;
    total_cnt++; if (pipe_stall !== 1'b0) $display("FAIL guard_stall_one_cycle got %b exp 0", pipe_stall); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL guard_busy_after got %b exp 0", busy); else pass_cnt++;
    step();
    drive_p(1'b0, 5'd0, 32'd0);
    total_cnt++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h99})
      $display("FAIL guard_represent got wen=%b a=%0d d=%h exp 1/9/99", rf_wen, rf_waddr, rf_wdata); else pass_cnt++;
`else
    for (int k = 0; k < 7; k++) begin
      drive_p(1'b1, 5'd9, 32'h90 + k);
      total_cnt++; if (pipe_stall !== 1'b0) $display("FAIL noguard_stall k=%0d got %b exp 0", k, pipe_stall); else pass_cnt++;
      step();
      total_cnt++; if ({rf_wen, rf_waddr, rf_wdata, busy} !== {1'b1, 5'd9, 32'h90 + k, 1'b1})
        $display("FAIL noguard_p_write k=%0d got wen=%b a=%0d d=%h busy=%b exp 1/9/%h/1", k, rf_wen, rf_waddr, rf_wdata, busy, 32'h90 + k); else pass_cnt++;
    end
    drive_p(1'b0, 5'd0, 32'd0);
    step();
    total_cnt++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd12, 32'hCC})
      $display("FAIL noguard_drain got wen=%b a=%0d d=%h exp 1/12/cc", rf_wen, rf_waddr, rf_wdata); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL noguard_busy_after got %b exp 0", busy); else pass_cnt++;
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_capture_drain();
    test_zero_addr();
    test_squash();
    test_back_to_back();
    test_starve();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
